spi_pixel_loader: RTL and testbench

Byte-stream command parser downstream of the SPI slave. It consumes received bytes (done/dout/selected), decodes a per-transaction command, and turns pixel payloads into single-cycle 24-bit RGB writes into the LED frame buffer. It also issues buffer-swap pulses and drives the status byte returned to the host on the slave's transmit input.

---
 rtl/spi_pixel_loader.sv | 148 ++++++++++++++
 tb/tb_spi_pixel_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader
// Byte-stream command parser sitting behind the SPI slave. Decodes one
// command per chip-select transaction, converts RGB payload bytes into
// single-cycle frame-buffer writes, issues buffer-swap pulses and keeps
// the status byte returned to the host up to date.
//
// Supported ADDR_WIDTH range is 9..16: the pixel pointer is built from the
// low (ADDR_WIDTH-8) bits of the high address byte plus the full low byte.

module spi_pixel_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  selected,
  output logic [7:0]            tx_byte,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [23:0]           wr_data,
  output logic                  frame_swap
);

  localparam int HI_W = ADDR_WIDTH - 8;

  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_SWAP      = 8'h02;
  localparam logic [7:0] CMD_CLEAR_ERR = 8'h03;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    PIX_R   = 3'd3,
    PIX_G   = 3'd4,
    PIX_B   = 3'd5,
    IGNORE  = 3'd6
  } state_t;

  state_t                state_reg, state_next;
  logic                  err_reg, err_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  sel_prev_reg;
  logic [HI_W-1:0]       addr_hi_reg;
  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic [7:0]            r_reg;
  logic [7:0]            g_reg;
  logic                  byte_ok;
  logic [ADDR_WIDTH-1:0] ptr_load;

  // A byte is accepted while selected, and also in the cycle where selected
  // has just fallen so a final byte coinciding with deselect is not lost.
  assign byte_ok  = rx_valid && (selected || sel_prev_reg);

  // Pointer load value; address bits above ADDR_WIDTH are simply dropped.
  assign ptr_load = {addr_hi_reg, rx_byte};

  // Next-state decode for the FSM and the status flags feeding tx_byte.
  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    if (byte_ok) begin
      case (state_reg)
        IDLE: begin
          case (rx_byte)
            CMD_WRITE: state_next = ADDR_HI;
            CMD_SWAP: begin
              cnt_next   = cnt_reg + 4'd1;
              state_next = IGNORE;
            end
            CMD_CLEAR_ERR: begin
              err_next   = 1'b0;
              state_next = IGNORE;
            end
            default: begin
              err_next   = 1'b1;
              state_next = IGNORE;
            end
          endcase
        end
        ADDR_HI: state_next = ADDR_LO;
        ADDR_LO: state_next = PIX_R;
        PIX_R:   state_next = PIX_G;
        PIX_G:   state_next = PIX_B;
        PIX_B:   state_next = PIX_R;
        IGNORE:  state_next = IGNORE;
        default: state_next = IDLE;
      endcase
    end
    // Deselect always ends the transaction, discarding partial data.
    if (!selected) begin
      state_next = IDLE;
    end
  end

  // Registered FSM state, datapath latches and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      err_reg      <= 1'b0;
      cnt_reg      <= 4'd0;
      sel_prev_reg <= 1'b0;
      addr_hi_reg  <= '0;
      ptr_reg      <= '0;
      r_reg        <= 8'd0;
      g_reg        <= 8'd0;
      tx_byte      <= 8'd0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 24'd0;
      frame_swap   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
      sel_prev_reg <= selected;
      // Built from next-state values so the host sees a byte's effect one
      // cycle after its rx_valid.
      tx_byte      <= {err_next, state_next, cnt_next};
      wr_en        <= 1'b0;
      frame_swap   <= 1'b0;
      if (byte_ok) begin
        case (state_reg)
          IDLE: begin
            if (rx_byte == CMD_SWAP) begin
              frame_swap <= 1'b1;
            end
          end
          ADDR_HI: addr_hi_reg <= rx_byte[HI_W-1:0];
          ADDR_LO: ptr_reg     <= ptr_load;
          PIX_R:   r_reg       <= rx_byte;
          PIX_G:   g_reg       <= rx_byte;
          PIX_B: begin
            wr_en   <= 1'b1;
            wr_addr <= ptr_reg;
            wr_data <= {r_reg, g_reg, rx_byte};
            // Wraps silently at the top of the frame buffer.
            ptr_reg <= ptr_reg + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Testbench for spi_pixel_loader: directed byte streams, expected writes and
// swap pulses queued by the stimulus and checked by an independent monitor.

module tb_spi_pixel_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'd0;
  logic          selected = 1'b0;
  logic [7:0]    tx_byte;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          frame_swap;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    int            cyc;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  int      swap_q[$];

  spi_pixel_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .selected   (selected),
    .tx_byte    (tx_byte),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_swap (frame_swap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: pops expected writes / swaps whenever the DUT presents one.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        check("write_addr", 32'(wr_addr), 32'(e.addr));
        check("write_data", 32'(wr_data), 32'(e.data));
        check("write_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (frame_swap) begin
      if (swap_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_swap: got pulse at cycle %0d expected none", cyc);
      end else begin
        int c;
        c = swap_q.pop_front();
        check("swap_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] b, input logic [AW-1:0] a, input logic [23:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + 1;
    wr_q.push_back(e);
    send(b);
  endtask

  task automatic send_swap();
    swap_q.push_back(cyc + 1);
    send(8'h02);
  endtask

  task automatic desel();
    selected = 1'b0;
    tick();
    tick();
    selected = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"}, 32'(tx_byte), 32'h00);
    check({tag, "_wr_en"}, 32'(wr_en), 32'h0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'h0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'h0);
    check({tag, "_swap"}, 32'(frame_swap), 32'h0);
  endtask

  initial begin
    tick(); tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Basic write of two pixels.
    selected = 1'b1;
    send(8'h01); send(8'h00); send(8'h05);
    send(8'hFF); send(8'h00); send_wr(8'h80, 10'h005, 24'hFF0080);
    send(8'h11); send(8'h22); send_wr(8'h33, 10'h006, 24'h112233);
    check("t1_tx_state_pix_r", 32'(tx_byte), 32'h30);
    desel();
    check("t1_tx_after_desel", 32'(tx_byte), 32'h00);

    // Pointer wrap, upper address bits dropped.
    send(8'h01); send(8'h07); send(8'hFF);
    send(8'hAA); send(8'hBB); send_wr(8'hCC, 10'h3FF, 24'hAABBCC);
    send(8'h01); send(8'h02); send_wr(8'h03, 10'h000, 24'h010203);
    desel();

    // Swaps: 17 total wraps frame_cnt to 1.
    send_swap();
    check("t3_tx_swap1", 32'(tx_byte), 32'h61);
    desel();
    send_swap();
    check("t3_tx_swap2", 32'(tx_byte), 32'h62);
    desel();
    for (int i = 0; i < 15; i++) begin
      send_swap();
      desel();
    end
    check("t3_tx_17_swaps", 32'(tx_byte), 32'h01);

    // Bad command sets sticky error; rest of transaction ignored.
    send(8'h55);
    send(8'h01); send(8'h00); send(8'h00);
    check("t4_tx_err_ignore", 32'(tx_byte), 32'hE1);
    desel();
    check("t4_tx_err_idle", 32'(tx_byte), 32'h81);
    send(8'h03);
    check("t4_tx_clear_err", 32'(tx_byte), 32'h61);
    desel();

    // Byte while deselected is ignored (no swap, count unchanged).
    selected = 1'b0;
    tick(); tick();
    send(8'h02);
    check("t4_desel_ignored", 32'(tx_byte), 32'h01);
    selected = 1'b1;

    // Partial pixel discarded across deselect.
    send(8'h01); send(8'h00); send(8'h10); send(8'hAA); send(8'hBB);
    desel();
    send(8'h01); send(8'h00); send(8'h20);
    send(8'h01); send(8'h02); send_wr(8'h03, 10'h020, 24'h010203);
    desel();

    // Final byte coinciding with deselect is processed, state ends IDLE.
    send(8'h01); send(8'h00); send(8'h40); send(8'h0A); send(8'h0B);
    selected = 1'b0;
    send_wr(8'h0C, 10'h040, 24'h0A0B0C);
    check("t5_tx_fall_idle", 32'(tx_byte), 32'h01);
    tick();
    selected = 1'b1;

    // Reset mid-stream.
    send(8'h01); send(8'h00); send(8'h10); send(8'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    desel();
    send_swap();
    check("t6_tx_after_rst_swap", 32'(tx_byte), 32'h61);
    desel();

    tick(); tick(); tick();
    check("leftover_writes", 32'(wr_q.size()), 32'd0);
    check("leftover_swaps", 32'(swap_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
